// File: rtl/qsys_shield_pio_irq.sv
// Shield pin event stage: two-flop sync, prescaled debounce, edge capture into
// sticky W1C flags, and a registered level interrupt on its own Avalon-MM slave.
module qsys_shield_pio_irq #(
  parameter int          WIDTH      = 26,
  parameter logic [31:0] PERIOD_RST = 32'd49999
) (
  input  logic             csi_MCLK_clk,
  input  logic             rsi_MRST_reset_n,
  input  logic [2:0]       avs_irq_address,
  input  logic [31:0]      avs_irq_writedata,
  input  logic [3:0]       avs_irq_byteenable,
  input  logic             avs_irq_write,
  input  logic             avs_irq_read,
  output logic [31:0]      avs_irq_readdata,
  output logic             avs_irq_waitrequest,
  input  logic [WIDTH-1:0] coe_pin_in,
  output logic             ins_INTRQ_irq
);

  logic [31:0]      lane_mask;
  logic [WIDTH-1:0] lane_w, wdata_w;
  logic             wr_cap, wr_mask, wr_rise, wr_fall, wr_period;
  logic [WIDTH-1:0] sync_p0, sync_p1, samp_p2, state_p2, state_d_p3;
  logic [WIDTH-1:0] capture, mask, rise_en, fall_en;
  logic [WIDTH-1:0] agree, rise, fall, clr;
  logic [31:0]      period, cnt;
  logic             tick;
  logic             unused_bits;

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                             input logic [WIDTH-1:0] data,
                                             input logic [WIDTH-1:0] lanes);
    return (old & ~lanes) | (data & lanes);
  endfunction

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  assign lane_mask = {{8{avs_irq_byteenable[3]}}, {8{avs_irq_byteenable[2]}},
                      {8{avs_irq_byteenable[1]}}, {8{avs_irq_byteenable[0]}}};
  assign lane_w    = lane_mask[WIDTH-1:0];
  assign wdata_w   = avs_irq_writedata[WIDTH-1:0];
  assign wr_cap    = avs_irq_write && (avs_irq_address == 3'd1);
  assign wr_mask   = avs_irq_write && (avs_irq_address == 3'd2);
  assign wr_rise   = avs_irq_write && (avs_irq_address == 3'd3);
  assign wr_fall   = avs_irq_write && (avs_irq_address == 3'd4);
  assign wr_period = avs_irq_write && (avs_irq_address == 3'd5);

  assign tick  = (cnt == period);
  assign agree = ~(sync_p1 ^ samp_p2);
  assign rise  = state_p2 & ~state_d_p3;
  assign fall  = ~state_p2 & state_d_p3;
  assign clr   = wr_cap ? (wdata_w & lane_w) : '0;

  assign avs_irq_waitrequest = 1'b0;
  assign unused_bits = ^{avs_irq_read, avs_irq_writedata, lane_mask};

  // Stage p0/p1: pad synchroniser
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= coe_pin_in;
      sync_p1 <= sync_p0;
    end
  end

  // A PERIOD write restarts the interval so the new terminal count is never overshot
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) cnt <= '0;
    else if (wr_period || tick) cnt <= '0;
    else cnt <= cnt + 32'd1;
  end

  // Stage p2: debounce on tick, p3: edge history
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      samp_p2    <= '0;
      state_p2   <= '0;
      state_d_p3 <= '0;
    end else begin
      if (tick) begin
        samp_p2  <= sync_p1;
        state_p2 <= merge(state_p2, sync_p1, agree);
      end
      state_d_p3 <= state_p2;
    end
  end

  // Set wins over clear so an edge coinciding with a W1C write is kept
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      capture       <= '0;
      mask          <= '0;
      rise_en       <= '0;
      fall_en       <= '0;
      period        <= PERIOD_RST;
      ins_INTRQ_irq <= 1'b0;
    end else begin
      capture       <= (capture & ~clr) | (rise & rise_en) | (fall & fall_en);
      ins_INTRQ_irq <= |(capture & mask);
      if (wr_mask)   mask    <= merge(mask, wdata_w, lane_w);
      if (wr_rise)   rise_en <= merge(rise_en, wdata_w, lane_w);
      if (wr_fall)   fall_en <= merge(fall_en, wdata_w, lane_w);
      if (wr_period) period  <= (period & ~lane_mask) | (avs_irq_writedata & lane_mask);
    end
  end

  always_comb begin
    avs_irq_readdata = 32'd0;
    case (avs_irq_address)
      3'd0:    avs_irq_readdata = zext(state_p2);
      3'd1:    avs_irq_readdata = zext(capture);
      3'd2:    avs_irq_readdata = zext(mask);
      3'd3:    avs_irq_readdata = zext(rise_en);
      3'd4:    avs_irq_readdata = zext(fall_en);
      3'd5:    avs_irq_readdata = period;
      default: avs_irq_readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_qsys_shield_pio_irq.sv
// Bench for qsys_shield_pio_irq: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the register/event rules.
module tb_qsys_shield_pio_irq;
  localparam int          W  = 26;
  localparam logic [31:0] WM = 32'h03FF_FFFF;
  localparam logic [31:0] PR = 32'd49999;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    addr;
  logic [31:0]   wd;
  logic [3:0]    be;
  logic          wr, rd;
  logic [31:0]   rdata;
  logic          waitreq;
  logic [W-1:0]  pins;
  logic          irq;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  qsys_shield_pio_irq #(.WIDTH(W), .PERIOD_RST(PR)) dut (
    .csi_MCLK_clk       (clk),
    .rsi_MRST_reset_n   (rst_n),
    .avs_irq_address    (addr),
    .avs_irq_writedata  (wd),
    .avs_irq_byteenable (be),
    .avs_irq_write      (wr),
    .avs_irq_read       (rd),
    .avs_irq_readdata   (rdata),
    .avs_irq_waitrequest(waitreq),
    .coe_pin_in         (pins),
    .ins_INTRQ_irq      (irq)
  );

  // Reference model state
  logic [31:0] m_s1, m_s2, m_samp, m_state, m_prev, m_cap, m_mask, m_re, m_fe, m_per, m_cnt;
  logic        m_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_reg(input logic [2:0] a);
    case (a)
      3'd0: return m_state;
      3'd1: return m_cap;
      3'd2: return m_mask;
      3'd3: return m_re;
      3'd4: return m_fe;
      3'd5: return m_per;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_samp = 0; m_state = 0; m_prev = 0; m_cap = 0;
    m_mask = 0; m_re = 0; m_fe = 0; m_cnt = 0; m_per = PR; m_irq = 1'b0;
  endtask

  // One clock edge of the rules, computed from pre-edge values
  task automatic model_step();
    logic [31:0] bm, clr, n_state, n_cap, n_cnt;
    logic        tick;
    bm = 0;
    for (int l = 0; l < 4; l++) if (be[l]) bm[l*8 +: 8] = 8'hFF;
    tick = (m_cnt == m_per);
    clr = (wr && addr == 3'd1) ? (wd & bm) : 32'd0;
    n_cap = 0;
    n_state = m_state;
    for (int i = 0; i < W; i++) begin
      n_cap[i] = (m_cap[i] && !clr[i]) ||
                 (m_state[i] && !m_prev[i] && m_re[i]) ||
                 (!m_state[i] && m_prev[i] && m_fe[i]);
      if (tick && (m_s2[i] == m_samp[i])) n_state[i] = m_s2[i];
    end
    if (wr && addr == 3'd5) n_cnt = 0;
    else if (tick)          n_cnt = 0;
    else                    n_cnt = m_cnt + 1;
    m_irq  = (m_cap & m_mask) != 0;
    if (tick) m_samp = m_s2;
    m_prev  = m_state;
    m_state = n_state;
    m_cap   = n_cap;
    m_cnt   = n_cnt;
    m_s2    = m_s1;
    m_s1    = {6'd0, pins};
    if (wr) begin
      case (addr)
        3'd2: m_mask = ((m_mask & ~bm) | (wd & bm)) & WM;
        3'd3: m_re   = ((m_re & ~bm) | (wd & bm)) & WM;
        3'd4: m_fe   = ((m_fe & ~bm) | (wd & bm)) & WM;
        3'd5: m_per  = (m_per & ~bm) | (wd & bm);
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    check("readdata", rdata, model_reg(addr));
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wd = d; be = b; wr = 1'b1;
    cycle();
    wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a,
                        input logic [31:0] msk, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata & msk, exp);
  endtask

  initial begin
    rst_n = 1'b0; addr = 0; wd = 0; be = 0; wr = 0; rd = 0;
    pins = '1;
    model_reset();

    // Reset and idle
    wait_cycles(3);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("waitreq", {31'd0, waitreq}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(20);
    rd_chk("idle_state", 0, 32'hFFFF_FFFF, 0);
    rd_chk("idle_cap",   1, 32'hFFFF_FFFF, 0);
    rd_chk("idle_mask",  2, 32'hFFFF_FFFF, 0);
    rd_chk("idle_per",   5, 32'hFFFF_FFFF, 32'd49999);
    rd_chk("idle_addr6", 6, 32'hFFFF_FFFF, 0);

    // Rising edge with PERIOD=0
    wr_reg(5, 0, 4'hF);
    wait_cycles(10);
    rd_chk("deb_state", 0, 32'hFFFF_FFFF, WM);
    pins = '0;
    wait_cycles(10);
    wr_reg(3, 1, 4'hF);
    wr_reg(2, 1, 4'hF);
    pins[0] = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      cycle();
      check("rise_irq", {31'd0, irq}, (j >= 6) ? 32'd1 : 32'd0);
      rd_chk("rise_state", 0, 32'hFFFF_FFFF, (j >= 4) ? 32'd1 : 32'd0);
      rd_chk("rise_cap",   1, 32'hFFFF_FFFF, (j >= 5) ? 32'd1 : 32'd0);
    end
    wr_reg(1, 1, 4'hF);
    rd_chk("w1c_cap", 1, 32'hFFFF_FFFF, 0);
    check("w1c_irq_hold", {31'd0, irq}, 32'd1);
    cycle();
    check("w1c_irq", {31'd0, irq}, 32'd0);

    // Falling edges and rise-only filter
    pins = 26'h7;
    wait_cycles(10);
    wr_reg(3, 2, 4'hF);
    wr_reg(4, 4, 4'hF);
    wr_reg(1, 32'hFFFF_FFFF, 4'hF);
    pins = 26'h1;
    wait_cycles(10);
    rd_chk("fall_cap", 1, 32'hFFFF_FFFF, 32'h4);
    pins = 26'h3;
    wait_cycles(10);
    rd_chk("rise1_cap", 1, 32'hFFFF_FFFF, 32'h6);

    // Glitch rejection with PERIOD=9
    wr_reg(3, 32'h8, 4'hF);
    wr_reg(4, 0, 4'hF);
    wr_reg(1, 32'hFFFF_FFFF, 4'hF);
    wr_reg(5, 9, 4'hF);
    pins[3] = 1'b1;
    wait_cycles(5);
    pins[3] = 1'b0;
    for (int j = 0; j < 30; j++) begin
      cycle();
      rd_chk("glitch_state", 0, 32'h8, 0);
    end
    rd_chk("glitch_cap", 1, 32'hFFFF_FFFF, 0);
    pins[3] = 1'b1;
    wait_cycles(22);
    rd_chk("hold_state", 0, 32'h8, 32'h8);
    wait_cycles(8);

    // W1C collision and byte lanes
    wr_reg(5, 0, 4'hF);
    wr_reg(3, 32'h20, 4'hF);
    wr_reg(1, 32'hFFFF_FFFF, 4'hF);
    wait_cycles(5);
    pins[5] = 1'b1;
    wait_cycles(4);
    wr_reg(1, 32'h20, 4'hF);
    rd_chk("collide_cap", 1, 32'h20, 32'h20);
    wr_reg(2, 0, 4'hF);
    wr_reg(2, 32'hFFFF_FFFF, 4'h1);
    rd_chk("lane_mask", 2, 32'hFFFF_FFFF, 32'hFF);
    cycle();
    check("mask_irq", {31'd0, irq}, 32'd1);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_irq", {31'd0, irq}, 32'd0);
    rd_chk("async_cap", 1, 32'hFFFF_FFFF, 0);
    rd_chk("async_per", 5, 32'hFFFF_FFFF, 32'd49999);
    wait_cycles(2);
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) pins[$urandom_range(0, W-1)] ^= 1'b1;
      wr = ($urandom_range(0, 5) == 0);
      rd = $urandom_range(0, 1) == 1;
      addr = 3'($urandom_range(0, 7));
      be = 4'($urandom_range(0, 15));
      wd = (addr == 3'd5) ? $urandom_range(0, 3) : $urandom;
      cycle();
      if (c == 2500) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rand_async_irq", {31'd0, irq}, 32'd0);
        wr = 1'b0;
        cycle();
        rst_n = 1'b1;
      end
    end
    wr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
